// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetcher feeding a DEPTH-entry queue
// towards decode, with local JAL resolution and stale-response dropping.
module fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_addr,
    input  logic              redir_en,
    input  logic [ADDR_W-1:0] redir_addr,
    output logic              req_en,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              resp_en,
    input  logic [INST_W-1:0] resp_inst,
    output logic              dec_valid,
    output logic [ADDR_W-1:0] dec_pc,
    output logic [INST_W-1:0] dec_inst,
    input  logic              dec_ready
);
    localparam int            PW     = $clog2(DEPTH);
    localparam int            CW     = PW + 1;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [6:0]    OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {IDLE, FETCH, WAIT_CT} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic              outstanding, outstanding_nx;
    logic              drop, drop_nx;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [INST_W-1:0] inst_q [DEPTH];
    logic              take, push, pop;
    logic [ADDR_W-1:0] j_imm;

    assign j_imm = {{(ADDR_W-20){resp_inst[31]}}, resp_inst[19:12],
                    resp_inst[20], resp_inst[30:21], 1'b0};

    assign req_addr  = pc;
    assign dec_valid = (count != '0);
    assign dec_pc    = pc_q[rd_ptr];
    assign dec_inst  = inst_q[rd_ptr];

    always_comb begin
        req_en = rdy && !flush && (state == FETCH) && !outstanding
                 && (count < FULL);
        take = rdy && !flush && resp_en && outstanding;
        push = take && !drop;
        pop  = rdy && !flush && dec_valid && dec_ready;
        state_nx       = state;
        pc_nx          = pc;
        outstanding_nx = outstanding;
        drop_nx        = drop;
        if (flush) begin
            state_nx = FETCH;
            pc_nx    = flush_addr;
            // a request still in flight must have its response swallowed
            outstanding_nx = outstanding && !resp_en;
            drop_nx        = outstanding && !resp_en;
        end else begin
            if (req_en) outstanding_nx = 1'b1;
            if (take) begin
                outstanding_nx = 1'b0;
                drop_nx        = 1'b0;
            end
            unique case (state)
                IDLE: begin
                    state_nx = FETCH;
                    pc_nx    = RESET_PC;
                end
                WAIT_CT: begin
                    if (redir_en) begin
                        state_nx = FETCH;
                        pc_nx    = redir_addr;
                    end
                end
                default: begin
                    if (push) begin
                        unique case (1'b1)
                            !resp_inst[6]:
                                pc_nx = pc + ADDR_W'(PC_STEP);
                            resp_inst[6:0] == OP_JAL:
                                pc_nx = pc + j_imm;
                            default:
                                state_nx = WAIT_CT;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else if (rdy) begin
            state       <= state_nx;
            pc          <= pc_nx;
            outstanding <= outstanding_nx;
            drop        <= drop_nx;
            if (flush) begin
                count  <= '0;
                wr_ptr <= rd_ptr;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else if (push) begin
            pc_q[wr_ptr]   <= pc;
            inst_q[wr_ptr] <= resp_inst;
        end
    end

endmodule
